// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, state encoding and zero-register constant
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int ZERO_REG       = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clr_if.sv
// rtl/regfile_clr_if.sv - register-file port bundle between initiator and register file
interface regfile_clr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) ();

  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic                  Ready;
  logic                  WriteDropped;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    input  ReadData1, ReadData2, Ready, WriteDropped
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    output ReadData1, ReadData2, Ready, WriteDropped
  );

endinterface

// File: rtl/regfile_clear_ctrl.sv
// rtl/regfile_clear_ctrl.sv - post-reset clear sequencer, Ready and sticky WriteDropped
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  i_reg_write,
  output logic                  o_ready,
  output logic                  o_write_dropped,
  output logic                  o_clear_en,
  output logic [ADDR_WIDTH-1:0] o_clear_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

  rf_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_clear_idx;
  logic                  r_ready;
  logic                  r_dropped;

  // Entry 0 is never stored, so the sweep starts at 1 and ends at DEPTH-1.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= CLEAR;
      r_clear_idx <= FIRST_IDX;
      r_ready     <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (i_reg_write) r_dropped <= 1'b1;
          if (r_clear_idx == LAST_IDX) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end else begin
            r_clear_idx <= r_clear_idx + FIRST_IDX;
          end
        end
        READY: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready         = r_ready;
  assign o_write_dropped = r_dropped;
  assign o_clear_en      = (r_state == CLEAR);
  assign o_clear_addr    = r_clear_idx;

endmodule

// File: rtl/regfile_clr.sv
// rtl/regfile_clr.sv - 2R1W register file with post-reset clear and write-through bypass
module regfile_clr
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic        Clk,
  input  logic        ResetN,
  regfile_clr_if.slave bus
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_ready;
  logic                  w_dropped;
  logic                  w_clear_en;
  logic [ADDR_WIDTH-1:0] w_clear_addr;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  regfile_clear_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_ctrl (
    .Clk             (Clk),
    .ResetN          (ResetN),
    .i_reg_write     (bus.RegWrite),
    .o_ready         (w_ready),
    .o_write_dropped (w_dropped),
    .o_clear_en      (w_clear_en),
    .o_clear_addr    (w_clear_addr)
  );

  // The clear sweep owns the write port; user writes are only accepted once Ready.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = w_clear_addr;
    w_wr_data = '0;
    if (w_clear_en) begin
      w_wr_en = 1'b1;
    end else if (bus.RegWrite && (bus.WriteRegister != ZERO_ADDR)) begin
      w_wr_en   = 1'b1;
      w_wr_addr = bus.WriteRegister;
      w_wr_data = bus.WriteData;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    if (addr == ZERO_ADDR || !w_ready)
      return '0;
    else if (bus.RegWrite && (bus.WriteRegister == addr))
      return bus.WriteData;
    else
      return r_mem[addr];
  endfunction

  always_comb begin
    w_rd1 = read_port(bus.ReadRegister1);
    w_rd2 = read_port(bus.ReadRegister2);
  end

  assign bus.ReadData1    = w_rd1;
  assign bus.ReadData2    = w_rd2;
  assign bus.Ready        = w_ready;
  assign bus.WriteDropped = w_dropped;

endmodule

// File: tb/tb_regfile_clr.sv
// tb/tb_regfile_clr.sv - directed self-checking bench for regfile_clr
module tb_regfile_clr;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  regfile_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk    (clk),
    .ResetN (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.RegWrite      = en;
    bus.WriteRegister = addr;
    bus.WriteData     = data;
  endtask

  task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
    bus.ReadRegister1 = a1;
    bus.ReadRegister2 = a2;
    #1;
  endtask

  // Caller has just released reset; 30 edges with Ready low, the 31st raises it.
  task automatic run_clear(input bit drop_last);
    for (int i = 1; i <= 30; i++) begin
      tick();
      check($sformatf("clr_rdy_lo_%0d", i), {31'd0, bus.Ready}, 32'd0);
    end
    if (drop_last) set_wr(1'b1, 5'd5, 32'd55);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    #1;
    check("clr_rdy_hi", {31'd0, bus.Ready}, 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd1, 5'd31);
    #3;
    check("rst_ready", {31'd0, bus.Ready}, 32'd0);
    check("rst_drop", {31'd0, bus.WriteDropped}, 32'd0);
    check("rst_rd1", bus.ReadData1, 32'd0);
    check("rst_rd2", bus.ReadData2, 32'd0);

    @(posedge clk);
    #2 rst_n = 1'b1;
    run_clear(1'b0);
    for (int i = 1; i < 32; i++) begin
      set_rd(5'(i), 5'(32 - i));
      check($sformatf("clr_zero_a_%0d", i), bus.ReadData1, 32'd0);
      check($sformatf("clr_zero_b_%0d", i), bus.ReadData2, 32'd0);
    end

    set_rd(5'd2, 5'd2);
    set_wr(1'b1, 5'd2, 32'd42);
    #1;
    check("byp42_p1", bus.ReadData1, 32'd42);
    check("byp42_p2", bus.ReadData2, 32'd42);
    tick();
    set_wr(1'b0, 5'd2, 32'd15);
    #1;
    check("mem42_p1", bus.ReadData1, 32'd42);
    check("mem42_p2", bus.ReadData2, 32'd42);
    set_wr(1'b1, 5'd2, 32'd15);
    #1;
    check("byp15_p1", bus.ReadData1, 32'd15);
    check("byp15_p2", bus.ReadData2, 32'd15);
    tick();
    set_wr(1'b0, 5'd2, 32'd16);
    #1;
    check("nowr_p1", bus.ReadData1, 32'd15);
    check("nowr_p2", bus.ReadData2, 32'd15);

    set_wr(1'b1, 5'd0, 32'd99);
    set_rd(5'd0, 5'd2);
    check("r0_byp", bus.ReadData1, 32'd0);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    #1;
    check("r0_read", bus.ReadData1, 32'd0);
    check("r0_r2", bus.ReadData2, 32'd15);
    check("r0_nodrop", {31'd0, bus.WriteDropped}, 32'd0);

    set_wr(1'b1, 5'd31, 32'hDEADBEEF);
    tick();
    set_wr(1'b1, 5'd1, 32'd7);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd31, 5'd1);
    check("swap_a_p1", bus.ReadData1, 32'hDEADBEEF);
    check("swap_a_p2", bus.ReadData2, 32'd7);
    set_rd(5'd1, 5'd31);
    check("swap_b_p1", bus.ReadData1, 32'd7);
    check("swap_b_p2", bus.ReadData2, 32'hDEADBEEF);

    rst_n = 1'b0;
    #1;
    check("rst2_ready", {31'd0, bus.Ready}, 32'd0);
    check("rst2_gate", bus.ReadData1, 32'd0);
    #2 rst_n = 1'b1;
    run_clear(1'b1);
    set_rd(5'd5, 5'd31);
    check("edge_drop", {31'd0, bus.WriteDropped}, 32'd1);
    check("edge_r5", bus.ReadData1, 32'd0);
    check("edge_r31", bus.ReadData2, 32'd0);
    tick();
    check("drop_sticky", {31'd0, bus.WriteDropped}, 32'd1);

    set_wr(1'b1, 5'd3, 32'h1234);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd3, 5'd3);
    check("r3_set", bus.ReadData1, 32'h1234);
    rst_n = 1'b0;
    #1;
    check("rst3_drop", {31'd0, bus.WriteDropped}, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) set_wr(1'b1, 5'd5, 32'd55);
      tick();
      set_wr(1'b0, 5'd0, 32'd0);
    end
    #1;
    check("mid_drop_set", {31'd0, bus.WriteDropped}, 32'd1);
    check("mid_not_ready", {31'd0, bus.Ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, bus.Ready}, 32'd0);
    check("mid_rst_drop", {31'd0, bus.WriteDropped}, 32'd0);
    #1 rst_n = 1'b1;
    run_clear(1'b0);
    set_rd(5'd3, 5'd5);
    check("post_r3", bus.ReadData1, 32'd0);
    check("post_r5", bus.ReadData2, 32'd0);
    check("post_drop", {31'd0, bus.WriteDropped}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
